// File: rtl/rx_inv_pkg.sv
// Shared types and width helpers for the 2x2 receive-covariance inverse.
package rx_inv_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DET  = 3'd2,
      DIV  = 3'd3,
      DONE = 3'd4
   } rx_inv_state_t;

   // Element being divided, in output order b11, b12, b21, b22.
   typedef logic [1:0] rx_inv_elem_t;

   localparam rx_inv_elem_t ELEM_B11 = 2'd0;
   localparam rx_inv_elem_t ELEM_B12 = 2'd1;
   localparam rx_inv_elem_t ELEM_B21 = 2'd2;
   localparam rx_inv_elem_t ELEM_B22 = 2'd3;

   // Determinant of two IN_W x IN_W products needs one extra bit for the difference.
   function automatic int det_w(input int in_w);
      return 2 * in_w + 1;
   endfunction

   // Numerator magnitude (IN_W+1 bits, covers +2^(IN_W-1)) shifted up by FRAC_W.
   function automatic int div_w(input int in_w, input int frac_w);
      return in_w + 1 + frac_w;
   endfunction

   // Symmetric saturation magnitude for an out_w-bit signed result.
   function automatic int sat_limit(input int out_w);
      return (1 << (out_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/rx_inv_divider.sv
// Serial restoring unsigned divider: one quotient bit per cycle, MSB first.
// done rises DIV_W cycles after the start cycle and stays high until the next start.
module rx_inv_divider #(
   parameter int DIV_W = 25,
   parameter int DVS_W = 32
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   // Remainder carries one spare bit so the shifted value never overflows.
   logic [DVS_W:0]   rem_q;
   logic [DIV_W-1:0] quo_q;
   logic [DVS_W-1:0] dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             loaded_q;

   logic [DVS_W+1:0] shifted;
   logic [DVS_W+1:0] trial;

   // Shift in the next dividend bit and try subtracting the divisor.
   always_comb begin
      shifted = {rem_q, quo_q[DIV_W-1]};
      trial   = shifted - {2'b00, dvs_q};
   end

   // Load on start, then one restoring step per cycle until the down-counter expires.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         loaded_q <= 1'b0;
      end else if (start) begin
         rem_q    <= '0;
         quo_q    <= dividend;
         dvs_q    <= divisor;
         cnt_q    <= CNT_W'(DIV_W);
         loaded_q <= 1'b1;
      end else if (cnt_q != '0) begin
         if (!trial[DVS_W+1]) begin
            rem_q <= trial[DVS_W:0];
            quo_q <= {quo_q[DIV_W-2:0], 1'b1};
         end else begin
            rem_q <= shifted[DVS_W:0];
            quo_q <= {quo_q[DIV_W-2:0], 1'b0};
         end
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign quotient = quo_q;
   assign done     = loaded_q && (cnt_q == '0);

endmodule

// File: rtl/rx_inverse_2x2.sv
// Fixed-point inverse of a held 2x2 covariance matrix: adj(Rx)/det(Rx).
// One shared serial divider is reused for all four elements.
// Optional macro RX_INV_SAT_FLAG_EN adds O_sat, flagging any clamped element.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a rising edge of I_rx_valid; inputs captured on it
// MUL   | form p0 = a11*a22 and p1 = a12*a21
// DET   | form det = p0 - p1; zero det skips straight to DONE
// DIV   | per element: start, DIV_W divider steps, store signed/clamped
// DONE  | publish results with a one-cycle O_inv_valid
module rx_inverse_2x2
   import rx_inv_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int FRAC_W = 8,
   parameter int OUT_W  = 16
) (
   input  logic                   I_sys_clk,
   input  logic                   I_sys_rstn,
   input  logic signed [IN_W-1:0] I_a11,
   input  logic signed [IN_W-1:0] I_a12,
   input  logic signed [IN_W-1:0] I_a21,
   input  logic signed [IN_W-1:0] I_a22,
   input  logic                   I_rx_valid,
   output logic [OUT_W-1:0]       O_b11,
   output logic [OUT_W-1:0]       O_b12,
   output logic [OUT_W-1:0]       O_b21,
   output logic [OUT_W-1:0]       O_b22,
   output logic                   O_inv_valid,
   output logic                   O_singular,
`ifdef RX_INV_SAT_FLAG_EN
   output logic                   O_sat,
`endif
   output logic                   O_busy
);

   localparam int DET_W   = det_w(IN_W);
   localparam int DIV_W   = div_w(IN_W, FRAC_W);
   localparam int DVS_W   = DET_W - 1;
   localparam int NUM_W   = IN_W + 1;
   localparam int PRD_W   = 2 * IN_W;
   localparam int SAT_LIM = sat_limit(OUT_W);

   rx_inv_state_t           state_q;
   rx_inv_elem_t            elem_q;
   logic                    div_iter_q;
   logic                    rx_valid_q;
   logic                    singular_q;
   logic signed [IN_W-1:0]  a11_q, a12_q, a21_q, a22_q;
   logic signed [PRD_W-1:0] p0_q, p1_q;
   logic signed [DET_W-1:0] det_q;
   logic [OUT_W-1:0]        res_q [4];
`ifdef RX_INV_SAT_FLAG_EN
   logic                    sat_acc_q;
`endif

   logic signed [DET_W-1:0] det_next;
   logic signed [NUM_W-1:0] num;
   logic [NUM_W-1:0]        num_mag;
   logic [DVS_W-1:0]        det_mag;
   logic [DIV_W-1:0]        dividend;
   logic [DIV_W-1:0]        quotient;
   logic                    div_start;
   logic                    div_done;
   logic                    clamp;
   logic                    elem_neg;
   logic [OUT_W-1:0]        mag;
   logic [OUT_W-1:0]        elem_val;

   // Determinant from the registered products, widened before subtracting.
   always_comb begin
      det_next = DET_W'(p0_q) - DET_W'(p1_q);
   end

   // Adjugate numerator for the current element; widened first so -(-2^(IN_W-1)) stays positive.
   always_comb begin
      num = NUM_W'(a22_q);
      case (elem_q)
         ELEM_B11: num = NUM_W'(a22_q);
         ELEM_B12: num = -NUM_W'(a12_q);
         ELEM_B21: num = -NUM_W'(a21_q);
         ELEM_B22: num = NUM_W'(a11_q);
         default:  num = NUM_W'(a22_q);
      endcase
   end

   // Magnitude-domain division operands, then sign restore and symmetric clamp of the quotient.
   always_comb begin
      num_mag   = num[NUM_W-1] ? -num : num;
      det_mag   = det_q[DET_W-1] ? DVS_W'(-det_q) : DVS_W'(det_q);
      dividend  = {num_mag, {FRAC_W{1'b0}}};
      div_start = (state_q == DIV) && !div_iter_q;
      clamp     = quotient > DIV_W'(SAT_LIM);
      mag       = clamp ? OUT_W'(SAT_LIM) : quotient[OUT_W-1:0];
      elem_neg  = (num[NUM_W-1] ^ det_q[DET_W-1]) && (quotient != '0);
      elem_val  = elem_neg ? -mag : mag;
   end

   rx_inv_divider #(
      .DIV_W (DIV_W),
      .DVS_W (DVS_W)
   ) u_div (
      .clk_sys  (I_sys_clk),
      .rst_b    (I_sys_rstn),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (det_mag),
      .quotient (quotient),
      .done     (div_done)
   );

   // Sequencer with all datapath and output registers; busy covers capture through the valid cycle.
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         state_q     <= IDLE;
         elem_q      <= ELEM_B11;
         div_iter_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         singular_q  <= 1'b0;
         a11_q       <= '0;
         a12_q       <= '0;
         a21_q       <= '0;
         a22_q       <= '0;
         p0_q        <= '0;
         p1_q        <= '0;
         det_q       <= '0;
         for (int i = 0; i < 4; i++) res_q[i] <= '0;
         O_b11       <= '0;
         O_b12       <= '0;
         O_b21       <= '0;
         O_b22       <= '0;
         O_inv_valid <= 1'b0;
         O_singular  <= 1'b0;
         O_busy      <= 1'b0;
`ifdef RX_INV_SAT_FLAG_EN
         sat_acc_q   <= 1'b0;
         O_sat       <= 1'b0;
`endif
      end else begin
         rx_valid_q  <= I_rx_valid;
         O_inv_valid <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (I_rx_valid && !rx_valid_q) begin
                  a11_q     <= I_a11;
                  a12_q     <= I_a12;
                  a21_q     <= I_a21;
                  a22_q     <= I_a22;
                  O_busy    <= 1'b1;
                  state_q   <= MUL;
`ifdef RX_INV_SAT_FLAG_EN
                  sat_acc_q <= 1'b0;
`endif
               end else begin
                  O_busy <= 1'b0;
               end
            end
            MUL: begin
               p0_q    <= PRD_W'(a11_q) * PRD_W'(a22_q);
               p1_q    <= PRD_W'(a12_q) * PRD_W'(a21_q);
               state_q <= DET;
            end
            DET: begin
               det_q      <= det_next;
               elem_q     <= ELEM_B11;
               div_iter_q <= 1'b0;
               singular_q <= (det_next == '0);
               state_q    <= (det_next == '0) ? DONE : DIV;
            end
            DIV: begin
               if (!div_iter_q) begin
                  div_iter_q <= 1'b1;
               end else if (div_done) begin
                  res_q[elem_q] <= elem_val;
                  div_iter_q    <= 1'b0;
`ifdef RX_INV_SAT_FLAG_EN
                  sat_acc_q     <= sat_acc_q | clamp;
`endif
                  if (elem_q == ELEM_B22) begin
                     state_q <= DONE;
                  end else begin
                     elem_q <= elem_q + 1'b1;
                  end
               end
            end
            DONE: begin
               O_b11       <= singular_q ? '0 : res_q[0];
               O_b12       <= singular_q ? '0 : res_q[1];
               O_b21       <= singular_q ? '0 : res_q[2];
               O_b22       <= singular_q ? '0 : res_q[3];
               O_singular  <= singular_q;
               O_inv_valid <= 1'b1;
`ifdef RX_INV_SAT_FLAG_EN
               O_sat       <= singular_q ? 1'b0 : sat_acc_q;
`endif
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_inverse_2x2.sv
// Directed bench for rx_inverse_2x2 with hand-computed expected inverses.
module tb_rx_inverse_2x2;

   logic        I_sys_clk  = 1'b0;
   logic        I_sys_rstn = 1'b0;
   logic [15:0] I_a11 = '0;
   logic [15:0] I_a12 = '0;
   logic [15:0] I_a21 = '0;
   logic [15:0] I_a22 = '0;
   logic        I_rx_valid = 1'b0;
   logic [15:0] O_b11, O_b12, O_b21, O_b22;
   logic        O_inv_valid, O_singular, O_busy;
`ifdef RX_INV_SAT_FLAG_EN
   logic        O_sat;
`endif

   int total = 0;
   int bad   = 0;
   int lat;
   int pulses;
   int first_lat;

   rx_inverse_2x2 dut (
      .I_sys_clk   (I_sys_clk),
      .I_sys_rstn  (I_sys_rstn),
      .I_a11       (I_a11),
      .I_a12       (I_a12),
      .I_a21       (I_a21),
      .I_a22       (I_a22),
      .I_rx_valid  (I_rx_valid),
      .O_b11       (O_b11),
      .O_b12       (O_b12),
      .O_b21       (O_b21),
      .O_b22       (O_b22),
      .O_inv_valid (O_inv_valid),
      .O_singular  (O_singular),
`ifdef RX_INV_SAT_FLAG_EN
      .O_sat       (O_sat),
`endif
      .O_busy      (O_busy)
   );

   always #5 I_sys_clk = ~I_sys_clk;

   task automatic chk(input string tag, input logic signed [39:0] obs, input logic signed [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_sys_clk);
      #1;
   endtask

   // Present a matrix with a rising I_rx_valid; returns just after the capture edge k.
   task automatic start_op(input int x11, input int x12, input int x21, input int x22);
      I_a11      = 16'(x11);
      I_a12      = 16'(x12);
      I_a21      = 16'(x21);
      I_a22      = 16'(x22);
      I_rx_valid = 1'b1;
      tick();
   endtask

   // Edges after k until O_inv_valid is seen, bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (O_inv_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_res(input string tag, input int e11, input int e12, input int e21,
                          input int e22, input int esing);
      chk({tag, ".b11"}, $signed(O_b11), e11);
      chk({tag, ".b12"}, $signed(O_b12), e12);
      chk({tag, ".b21"}, $signed(O_b21), e21);
      chk({tag, ".b22"}, $signed(O_b22), e22);
      chk({tag, ".singular"}, O_singular, esing);
   endtask

   task automatic idle_gap();
      I_rx_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk_res("rst", 0, 0, 0, 0, 0);
      chk("rst.valid", O_inv_valid, 0);
      chk("rst.busy", O_busy, 0);
      I_sys_rstn = 1'b1;
      tick();
      chk("idle.busy", O_busy, 0);

      // det = 12 - 4 = 8
      start_op(4, 2, 2, 3);
      chk("t1.busy", O_busy, 1);
      wait_valid(lat);
      chk("t1.latency", lat, 111);
      chk_res("t1", 96, -64, -64, 128, 0);
`ifdef RX_INV_SAT_FLAG_EN
      chk("t1.sat", O_sat, 0);
`endif
      chk("t1.busy_at_valid", O_busy, 1);
      tick();
      chk("t1.valid_one_cycle", O_inv_valid, 0);
      chk("t1.busy_clear", O_busy, 0);
      repeat (5) tick();
      chk("t1.held_level_no_retrig", O_busy, 0);
      chk("t1.hold_b12", $signed(O_b12), -64);
      idle_gap();

      // det = 4 - 4 = 0
      start_op(2, 4, 1, 2);
      wait_valid(lat);
      chk("t2.latency", lat, 3);
      chk_res("t2", 0, 0, 0, 0, 1);
      idle_gap();

      // det = -1: sign of quotient follows num XOR det, zero stays zero
      start_op(0, 1, 1, 0);
      wait_valid(lat);
      chk("t3.latency", lat, 111);
      chk_res("t3", 0, 256, 256, 0, 0);
      idle_gap();

      // det = 1, b12 = 200*256 clamps positive
      start_op(1, -200, 0, 1);
      wait_valid(lat);
      chk_res("t4", 256, 32767, 0, 256, 0);
`ifdef RX_INV_SAT_FLAG_EN
      chk("t4.sat", O_sat, 1);
`endif
      idle_gap();

      // det = 1, b12 = -200*256 clamps symmetrically negative
      start_op(1, 200, 0, 1);
      wait_valid(lat);
      chk_res("t5", 256, -32767, 0, 256, 0);
      idle_gap();

      // det = 35 - 6 = 29: truncation toward zero on magnitudes
      start_op(5, 3, 2, 7);
      wait_valid(lat);
      chk_res("t6", 61, -26, -17, 44, 0);
      idle_gap();

      // Rise at k+50 while busy is ignored; rise at k+112 is accepted
      start_op(5, 3, 2, 7);
      pulses    = 0;
      first_lat = 0;
      for (int c = 1; c <= 111; c++) begin
         tick();
         if (O_inv_valid === 1'b1) begin
            pulses++;
            if (first_lat == 0) first_lat = c;
         end
         if (c == 10) I_rx_valid = 1'b0;
         if (c == 49) begin
            I_a11 = 16'd4;
            I_a12 = 16'd2;
            I_a21 = 16'd2;
            I_a22 = 16'd3;
            I_rx_valid = 1'b1;
         end
         if (c == 100) I_rx_valid = 1'b0;
      end
      chk("t7.pulses", pulses, 1);
      chk("t7.latency", first_lat, 111);
      chk_res("t7", 61, -26, -17, 44, 0);
      I_rx_valid = 1'b1;
      tick();
      chk("t7b.busy", O_busy, 1);
      wait_valid(lat);
      chk("t7b.latency", lat, 111);
      chk_res("t7b", 96, -64, -64, 128, 0);
      idle_gap();

      // Reset at k+60 aborts the operation
      start_op(5, 3, 2, 7);
      repeat (59) tick();
      #2;
      I_sys_rstn = 1'b0;
      I_rx_valid = 1'b0;
      #1;
      chk("t8.rst_b11", $signed(O_b11), 0);
      chk("t8.rst_busy", O_busy, 0);
      chk("t8.rst_valid", O_inv_valid, 0);
      tick();
      tick();
      I_sys_rstn = 1'b1;
      pulses = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (O_inv_valid === 1'b1) pulses++;
      end
      chk("t8.no_pulse", pulses, 0);
      chk("t8.b22_zero", $signed(O_b22), 0);
      // det = 9 - 1 = 8
      start_op(3, 1, 1, 3);
      wait_valid(lat);
      chk("t8.latency", lat, 111);
      chk_res("t8", 96, -32, -32, 96, 0);
      idle_gap();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
